// File: rtl/md_issue_ctrl.sv
// Purpose: E-stage initiator for the mult/div unit (issue, BUSY tracking, HI/LO readback, hang detect).
// Latency: START/op/operands registered one cycle after accept; mfhi/mflo data is combinational in IDLE.
// Backpressure: stall_e holds md-class E instructions while an op is in flight; non-md never stalls.
//
// Ports:
//   clk, reset (async, active-low)
//   e_valid, e_op[3:0], e_rs, e_rt, int_req      - E-stage instruction and squash
//   xalu_busy, xalu_hi, xalu_lo                  - status/results from the unit
//   xalu_start, xalu_op[2:0], xalu_a, xalu_b,
//   xalu_int_req                                 - registered controls to the unit
//   stall_e, md_result, md_result_valid, err     - pipeline side
module md_issue_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CW      = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_valid,
    input  logic [3:0]  e_op,
    input  logic [31:0] e_rs,
    input  logic [31:0] e_rt,
    input  logic        int_req,
    input  logic        xalu_busy,
    input  logic [31:0] xalu_hi,
    input  logic [31:0] xalu_lo,
    output logic        xalu_start,
    output logic [2:0]  xalu_op,
    output logic [31:0] xalu_a,
    output logic [31:0] xalu_b,
    output logic        xalu_int_req,
    output logic        stall_e,
    output logic [31:0] md_result,
    output logic        md_result_valid,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_MT    = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    localparam logic [2:0]    OP_IDLE = 3'b111;
    localparam logic [CW-1:0] TMO     = CW'(TIMEOUT);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          md_class;
    logic          accept;
    logic [3:0]    op_m1;

    assign md_class = e_valid && (e_op >= 4'd1) && (e_op <= 4'd8);
    assign accept   = md_class && (state == S_IDLE) && !int_req;
    assign op_m1    = e_op - 4'd1;

    // The unit cannot abort, so interrupts are filtered here and never forwarded.
    assign xalu_int_req = 1'b0;

    // Anything md-class must wait until the unit is back to IDLE; an accepted
    // instruction is by definition in IDLE and so never stalled.
    assign stall_e = md_class && (state != S_IDLE);

    always_comb begin
        md_result_valid = 1'b0;
        md_result       = 32'd0;
        if ((state == S_IDLE) && e_valid && !int_req &&
            ((e_op == 4'd7) || (e_op == 4'd8))) begin
            md_result_valid = 1'b1;
            md_result       = (e_op == 4'd7) ? xalu_hi : xalu_lo;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            xalu_start <= 1'b0;
            xalu_op    <= OP_IDLE;
            xalu_a     <= 32'd0;
            xalu_b     <= 32'd0;
            cnt        <= '0;
            err        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && (e_op <= 4'd4)) begin
                        xalu_start <= 1'b1;
                        xalu_op    <= op_m1[2:0];
                        xalu_a     <= e_rs;
                        xalu_b     <= e_rt;
                        state      <= S_START;
                    end else if (accept && ((e_op == 4'd5) || (e_op == 4'd6))) begin
                        xalu_op <= (e_op == 4'd5) ? 3'b100 : 3'b101;
                        xalu_a  <= e_rs;
                        state   <= S_MT;
                    end
                end
                S_START: begin
                    xalu_start <= 1'b0;
                    xalu_op    <= OP_IDLE;
                    cnt        <= '0;
                    state      <= S_WAIT;
                end
                S_MT: begin
                    xalu_op <= OP_IDLE;
                    state   <= S_IDLE;
                end
                S_WAIT: begin
                    if (xalu_busy) begin
                        // Saturate so a hung unit cannot wrap the counter and clear the condition.
                        if (cnt != TMO) begin
                            cnt <= cnt + CW'(1);
                        end
                        // err rises on the same edge the counter reaches TIMEOUT.
                        if (cnt == (TMO - CW'(1))) begin
                            err <= 1'b1;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_issue_ctrl.sv
module tb_md_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        e_valid;
    logic [3:0]  e_op;
    logic [31:0] e_rs, e_rt;
    logic        int_req;
    logic        xalu_busy;
    logic [31:0] xalu_hi, xalu_lo;
    logic        xalu_start;
    logic [2:0]  xalu_op;
    logic [31:0] xalu_a, xalu_b;
    logic        xalu_int_req;
    logic        stall_e;
    logic [31:0] md_result;
    logic        md_result_valid;
    logic        err;

    int checks = 0;
    int errors = 0;

    md_issue_ctrl #(.TIMEOUT(16), .CW(5)) dut (
        .clk(clk), .reset(reset),
        .e_valid(e_valid), .e_op(e_op), .e_rs(e_rs), .e_rt(e_rt), .int_req(int_req),
        .xalu_busy(xalu_busy), .xalu_hi(xalu_hi), .xalu_lo(xalu_lo),
        .xalu_start(xalu_start), .xalu_op(xalu_op), .xalu_a(xalu_a), .xalu_b(xalu_b),
        .xalu_int_req(xalu_int_req), .stall_e(stall_e),
        .md_result(md_result), .md_result_valid(md_result_valid), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The model thinks in terms of "what the unit is doing": a START pulse
    // outstanding, an MT write outstanding, or waiting for BUSY to drop.
    // Any of those makes the unit unavailable to a new md instruction.
    logic        m_start;
    logic [2:0]  m_op;
    logic [31:0] m_a, m_b;
    logic        m_err;
    bit          m_waiting;
    int          m_busy_cycles;

    function automatic bit is_md(input logic v, input logic [3:0] op);
        return v && (op >= 1) && (op <= 8);
    endfunction

    function automatic bit unit_unavailable();
        return m_start || (m_op == 3'b100) || (m_op == 3'b101) || m_waiting;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_start = 0; m_op = 3'b111; m_a = 0; m_b = 0; m_err = 0;
            m_waiting = 0; m_busy_cycles = 0;
        end else if (m_start) begin
            m_start = 0; m_op = 3'b111; m_waiting = 1; m_busy_cycles = 0;
        end else if (m_op == 3'b100 || m_op == 3'b101) begin
            m_op = 3'b111;
        end else if (m_waiting) begin
            if (xalu_busy) begin
                m_busy_cycles++;
                if (m_busy_cycles >= 16) m_err = 1;
            end else begin
                m_waiting = 0;
            end
        end else if (is_md(e_valid, e_op) && !int_req) begin
            if (e_op <= 4) begin
                m_start = 1; m_op = 3'(e_op - 1); m_a = e_rs; m_b = e_rt;
            end else if (e_op == 5 || e_op == 6) begin
                m_op = (e_op == 5) ? 3'b100 : 3'b101; m_a = e_rs;
            end
        end
    end

    // Single compare process: every falling edge out of reset.
    always @(negedge clk) begin
        if (reset) begin
            logic exp_stall, exp_vld;
            exp_stall = is_md(e_valid, e_op) && unit_unavailable();
            exp_vld   = e_valid && (e_op == 7 || e_op == 8) && !int_req && !unit_unavailable();
            chk("m_start", 32'(xalu_start), 32'(m_start));
            chk("m_op",    32'(xalu_op),    32'(m_op));
            chk("m_a",     xalu_a,          m_a);
            chk("m_b",     xalu_b,          m_b);
            chk("m_err",   32'(err),        32'(m_err));
            chk("m_stall", 32'(stall_e),    32'(exp_stall));
            chk("m_vld",   32'(md_result_valid), 32'(exp_vld));
            chk("m_intreq", 32'(xalu_int_req), 32'd0);
            if (exp_vld)
                chk("m_result", md_result, (e_op == 7) ? xalu_hi : xalu_lo);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op,
                         input logic [31:0] rs, input logic [31:0] rt);
        e_valid = v; e_op = op; e_rs = rs; e_rt = rt;
    endtask

    initial begin
        reset = 0; drive(0, 0, 0, 0); int_req = 0; xalu_busy = 0;
        xalu_hi = 32'h0; xalu_lo = 32'h0;
        repeat (2) cyc();
        chk("rst_start", 32'(xalu_start), 32'd0);
        chk("rst_op",    32'(xalu_op),    32'd7);
        chk("rst_a",     xalu_a,          32'd0);
        chk("rst_err",   32'(err),        32'd0);
        reset = 1;
        cyc();

        // mult -7 * 3, then back-to-back mflo
        drive(1, 1, 32'hFFFFFFF9, 32'h00000003);
        cyc();
        chk("mult_start", 32'(xalu_start), 32'd1);
        chk("mult_op",    32'(xalu_op),    32'd0);
        chk("mult_a",     xalu_a,          32'hFFFFFFF9);
        chk("mult_b",     xalu_b,          32'h00000003);
        drive(1, 8, 0, 0);
        #1 chk("mflo_stall_start", 32'(stall_e), 32'd1);
        cyc();
        chk("mult_start_drop", 32'(xalu_start), 32'd0);
        xalu_busy = 1;
        repeat (4) cyc();
        chk("mflo_stall_wait", 32'(stall_e), 32'd1);
        xalu_busy = 0; xalu_hi = 32'hFFFFFFFF; xalu_lo = 32'hFFFFFFEB;
        cyc();
        chk("mflo_vld",   32'(md_result_valid), 32'd1);
        chk("mflo_data",  md_result,            32'hFFFFFFEB);
        chk("mflo_nostall", 32'(stall_e),       32'd0);
        drive(0, 0, 0, 0);
        cyc();

        // div squashed by interrupt, then issued
        drive(1, 3, 32'd100, 32'd7); int_req = 1;
        #1 chk("div_int_stall", 32'(stall_e), 32'd0);
        cyc();
        chk("div_int_nostart", 32'(xalu_start), 32'd0);
        int_req = 0;
        cyc();
        chk("div_start", 32'(xalu_start), 32'd1);
        chk("div_op",    32'(xalu_op),    32'd2);
        drive(0, 0, 0, 0);
        repeat (2) cyc();

        // mthi then mfhi: one MT stall cycle
        drive(1, 5, 32'h12345678, 32'h0);
        cyc();
        chk("mthi_op", 32'(xalu_op), 32'd4);
        chk("mthi_a",  xalu_a,       32'h12345678);
        drive(1, 7, 0, 0); xalu_hi = 32'h12345678;
        #1 chk("mfhi_stall", 32'(stall_e), 32'd1);
        cyc();
        chk("mt_op_idle", 32'(xalu_op), 32'd7);
        chk("mfhi_vld",   32'(md_result_valid), 32'd1);
        chk("mfhi_data",  md_result, 32'h12345678);
        drive(0, 0, 0, 0);
        cyc();

        // hung unit: err after 16 busy WAIT cycles, sticky
        drive(1, 2, 32'd5, 32'd6);
        cyc();
        drive(0, 0, 0, 0);
        cyc();
        xalu_busy = 1;
        repeat (15) cyc();
        chk("err_before", 32'(err), 32'd0);
        cyc();
        chk("err_set", 32'(err), 32'd1);
        drive(1, 9, 0, 0);
        #1 chk("op9_nostall", 32'(stall_e), 32'd0);
        cyc();
        drive(0, 1, 32'hDEAD, 32'hBEEF);
        repeat (3) cyc();
        xalu_busy = 0;
        cyc();
        chk("err_sticky", 32'(err), 32'd1);
        cyc();
        chk("nv_noissue", 32'(xalu_start), 32'd0);

        // async reset mid-WAIT
        drive(1, 1, 32'd9, 32'd9);
        cyc();
        drive(0, 0, 0, 0);
        cyc();
        xalu_busy = 1;
        cyc();
        #3 reset = 0;
        #1;
        chk("arst_op",  32'(xalu_op), 32'd7);
        chk("arst_a",   xalu_a,       32'd0);
        chk("arst_b",   xalu_b,       32'd0);
        chk("arst_err", 32'(err),     32'd0);
        xalu_busy = 0;
        cyc();
        reset = 1;
        drive(1, 7, 0, 0); xalu_hi = 32'hCAFEF00D;
        #1;
        chk("post_rst_stall", 32'(stall_e), 32'd0);
        chk("post_rst_vld",   32'(md_result_valid), 32'd1);
        chk("post_rst_data",  md_result, 32'hCAFEF00D);
        cyc();
        drive(0, 0, 0, 0);
        repeat (2) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/md_issue_ctrl.md
Name: md_issue_ctrl

Overview:
- Pipeline-side initiator for the multiply/divide unit (XALU); sits in the E stage.
- Accepts decoded mult/multu/div/divu/mthi/mtlo/mfhi/mflo from the pipeline and drives the unit's START/op/operand inputs with a registered one-cycle START pulse.
- Tracks the unit's BUSY, stalls E-stage md-class instructions while an operation is in flight, and returns HI/LO for mfhi/mflo.
- Filters interrupts before issue and flags a hung unit.

Parameters:
- TIMEOUT, 16, max WAIT cycles with BUSY high before err is set.
- CW, 5, width of the WAIT cycle counter; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- e_valid  in  1  E-stage instruction valid.
- e_op  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9-15 treated as none.
- e_rs  in  32  rs operand (forwarded).
- e_rt  in  32  rt operand (forwarded).
- int_req  in  1  interrupt/exception taken this cycle; the E instruction is squashed.
- xalu_busy  in  1  BUSY from the unit.
- xalu_hi  in  32  HI from the unit.
- xalu_lo  in  32  LO from the unit.
- xalu_start  out  1  START to the unit.
- xalu_op  out  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 111 idle.
- xalu_a  out  32  operand A (rs).
- xalu_b  out  32  operand B (rt).
- xalu_int_req  out  1  IntReq to the unit; tied 0 (filtering is done here).
- stall_e  out  1  hold the E stage (combinational).
- md_result  out  32  mfhi/mflo data (combinational).
- md_result_valid  out  1  md_result valid this cycle.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset (async, reset=0): state IDLE; xalu_start=0; xalu_op=111; xalu_a=0; xalu_b=0; cnt=0; err=0. Reset mid-operation discards all tracking. After reset release, IDLE; the pipeline's reset also resets the unit.
- "md-class" means e_valid=1 and e_op in 1..8. "accept" means md-class, state==IDLE, int_req=0.
- IDLE:
  - accept of op 1-4 -> registered: xalu_start=1, xalu_op=e_op-1, xalu_a=e_rs, xalu_b=e_rt; go to START.
  - accept of op 5/6 -> xalu_op=100/101, xalu_a=e_rs, xalu_start=0; go to MT.
  - op 7/8 with int_req=0 -> md_result = xalu_hi / xalu_lo; md_result_valid=1; no state change.
- START (exactly 1 cycle): xalu_start=1; the unit samples it at this edge. Next: xalu_start=0, xalu_op=111, cnt=0; go to WAIT.
- MT (exactly 1 cycle): the unit writes HI/LO at this edge. Next: xalu_op=111; go to IDLE.
- WAIT:
  - Each cycle with xalu_busy=1, cnt increments (saturating at TIMEOUT). When cnt==TIMEOUT, set err=1 (sticky until reset); stay in WAIT.
  - xalu_busy=0 -> IDLE next cycle. HI/LO are valid in that IDLE cycle.
- stall_e = md-class and state!=IDLE. Non-md instructions never stall. An accepted instruction is not stalled.
- int_req=1: no accept and no md_result_valid that cycle. In-flight START/WAIT/MT ops complete (the unit cannot abort). stall_e still follows the rule above.
- Back-to-back: mult then mfhi -> mfhi stalls through START and WAIT and reads in the first IDLE cycle. mthi then mfhi -> exactly 1 stall cycle (MT).
- xalu_a/xalu_b hold their value outside issue. Arithmetic is done by the unit only; no width conversion here.

Test Plan:
- Reset, then mult (op 1) rs=FFFFFFF9, rt=00000003 -> next cycle xalu_start=1, op=000, a=FFFFFFF9, b=3 for exactly one cycle. Model unit BUSY for 4 cycles. Back-to-back mflo stalls every cycle until IDLE, then returns FFFFFFEB with valid=1.
- div (op 3) asserted with int_req=1 -> no start, state stays IDLE, stall_e=0. Same div without int_req -> issues op 010.
- mthi rs=12345678, then mfhi -> one stall cycle, xalu_op=100 for one cycle, then md_result=xalu_hi (12345678), valid=1.
- Hold xalu_busy=1 after start -> err rises after 16 WAIT cycles and stays 1. Deassert busy -> IDLE, err still 1.
- Assert reset=0 mid-WAIT (asynchronously, between edges) -> outputs return to reset values immediately. After release, mfhi is accepted without stall.
- e_op=9 with e_valid=1 while in WAIT -> stall_e=0; e_valid=0 with op 1 -> no issue.
